// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider sequencer for DIV.W/DIV.WU/MOD.W/MOD.WU.
// Latches operands on start, iterates 32 times, and holds {remainder, quotient} until acknowledged.
module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        cancel_i,
    input  logic        ack_i,
    output logic [63:0] result_o,
    output logic        done_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_ZERO,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [4:0]  r_cnt;
    logic [63:0] r_result;

    logic        r_sa;
    logic        r_sb;
    logic [31:0] r_b_abs;
    logic [31:0] r_dividend_raw;
    logic [63:0] r_rq;

    logic        w_accept;
    logic        w_sa;
    logic        w_sb;
    logic [31:0] w_a_abs;
    logic [31:0] w_b_abs;

    logic [32:0] w_t;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_r_next;
    logic [31:0] w_q_next;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    // Operand capture: signs are only meaningful for signed operations.
    assign w_accept = (r_state == S_IDLE) && start_i && !cancel_i;
    assign w_sa     = signed_i & dividend_i[31];
    assign w_sb     = signed_i & divisor_i[31];
    assign w_a_abs  = w_sa ? (~dividend_i + 32'd1) : dividend_i;
    assign w_b_abs  = w_sb ? (~divisor_i + 32'd1) : divisor_i;

    // One restoring step; the 33-bit compare keeps 0x8000_0000 magnitudes exact.
    assign w_t      = {r_rq[63:32], r_rq[31]};
    assign w_diff   = w_t - {1'b0, r_b_abs};
    assign w_ge     = (w_t >= {1'b0, r_b_abs});
    assign w_r_next = w_ge ? w_diff[31:0] : w_t[31:0];
    assign w_q_next = {r_rq[30:0], w_ge};

    // Remainder follows the dividend's sign; quotient follows the sign product.
    assign w_quo_fix = (r_sa ^ r_sb) ? (~w_q_next + 32'd1) : w_q_next;
    assign w_rem_fix = r_sa ? (~w_r_next + 32'd1) : w_r_next;

    // NOTE: sequential state is written with non-blocking (<=) so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        // NOTE: the default assignment first guarantees no latch is inferred
        // for paths where no branch below assigns w_next.
        w_next = r_state;
        if (cancel_i) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        w_next = (divisor_i == 32'd0) ? S_ZERO : S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == 5'd31) begin
                        w_next = S_DONE;
                    end
                end
                S_ZERO:  w_next = S_DONE;
                S_DONE: begin
                    if (ack_i) begin
                        w_next = S_IDLE;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Architecturally visible state: counter and held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= 5'd0;
            r_result <= 64'd0;
        end else begin
            if (w_accept) begin
                r_cnt <= 5'd0;
            end else if (r_state == S_BUSY && !cancel_i) begin
                r_cnt <= r_cnt + 5'd1;
            end

            if (r_state == S_BUSY && w_next == S_DONE) begin
                r_result <= {w_rem_fix, w_quo_fix};
            end else if (r_state == S_ZERO && w_next == S_DONE) begin
                r_result <= {r_dividend_raw, 32'hFFFF_FFFF};
            end
        end
    end

    // NOTE: the working registers carry no reset; every operation reloads them
    // on acceptance before any of their bits can reach an output.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_sa           <= w_sa;
            r_sb           <= w_sb;
            r_b_abs        <= w_b_abs;
            r_dividend_raw <= dividend_i;
            r_rq           <= {32'd0, w_a_abs};
        end else if (r_state == S_BUSY) begin
            r_rq <= {w_r_next, w_q_next};
        end
    end

    assign result_o = r_result;
    assign done_o   = (r_state == S_DONE);
    assign busy_o   = (r_state == S_BUSY) || (r_state == S_ZERO);

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed corner cases plus randomized operations
// compared against an arithmetic reference model.
module tb_div_ctrl;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        cancel_i;
    logic        ack_i;
    logic [63:0] result_o;
    logic        done_o;
    logic        busy_o;

    int          n_vec;
    int          n_err;
    logic [63:0] last_res;

    div_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .cancel_i   (cancel_i),
        .ack_i      (ack_i),
        .result_o   (result_o),
        .done_o     (done_o),
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Division semantics as the ISA defines them, using plain language arithmetic.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (!s) return {a % b, a / b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {32'(r), 32'(q)};
    endfunction

    function automatic logic [31:0] pick_operand(input bit allow_zero);
        int sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0: return allow_zero ? 32'd0 : 32'd1;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'(($urandom_range(0, 1) == 1) ? 1 : 2);
            4, 5: return 32'($urandom_range(0, 1000));
            6: return 32'hFFFF_FFFF - 32'($urandom_range(0, 1000));
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge while the DUT is idle. Leaves the DUT idle at a negedge.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input int ack_wait);
        logic [63:0] exp;
        int          lat;
        int          n;
        bit          seen;
        exp        = model(a, b, s);
        lat        = (b == 32'd0) ? 2 : 33;
        start_i    = 1'b1;
        signed_i   = s;
        dividend_i = a;
        divisor_i  = b;
        seen       = 0;
        n          = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            // Operands must only be sampled in IDLE.
            dividend_i = $urandom;
            divisor_i  = $urandom;
            signed_i   = 1'($urandom_range(0, 1));
            if (done_o) seen = 1;
            else check({tag, " busy"}, 64'(busy_o), 64'd1);
        end
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " result"}, result_o, exp);
        for (int i = 0; i < ack_wait; i++) begin
            start_i = 1'($urandom_range(0, 1));
            ack_i   = 1'b0;
            @(negedge clk);
            check({tag, " hold done"}, 64'(done_o), 64'd1);
            check({tag, " hold result"}, result_o, exp);
        end
        start_i = 1'b0;
        ack_i   = 1'b1;
        @(negedge clk);
        ack_i = 1'b0;
        check({tag, " ack idle"}, {62'd0, done_o, busy_o}, 64'd0);
        check({tag, " ack result"}, result_o, exp);
        last_res = exp;
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        last_res   = 64'd0;
        rst        = 1'b1;
        start_i    = 1'b0;
        signed_i   = 1'b0;
        dividend_i = 32'd0;
        divisor_i  = 32'd0;
        cancel_i   = 1'b0;
        ack_i      = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs", {result_o, 62'd0, done_o, busy_o} == 128'd0 ? 64'd0 : 64'd1, 64'd0);
        check("reset result", result_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        run_op("u100/7",        32'd100,         32'd7,           1'b0, 0);
        check("u100/7 value", last_res, {32'd2, 32'd14});
        run_op("s-7/2",         32'hFFFF_FFF9,   32'd2,           1'b1, 1);
        run_op("s7/-2",         32'd7,           32'hFFFF_FFFE,   1'b1, 0);
        run_op("u5/0",          32'd5,           32'd0,           1'b0, 2);
        run_op("s5/0",          32'd5,           32'd0,           1'b1, 0);
        run_op("s-5/0",         32'hFFFF_FFFB,   32'd0,           1'b1, 0);
        run_op("s_ovf",         32'h8000_0000,   32'hFFFF_FFFF,   1'b1, 0);
        run_op("umax/1",        32'hFFFF_FFFF,   32'd1,           1'b0, 0);
        run_op("u_big",         32'h8000_0000,   32'h8000_0000,   1'b0, 0);
        run_op("hold3",         32'd1000,        32'd33,          1'b0, 3);

        // Cancel at cycle 10, then a fresh 9/3 in the very next cycle.
        start_i    = 1'b1;
        signed_i   = 1'b0;
        dividend_i = 32'd100;
        divisor_i  = 32'd7;
        repeat (10) begin
            @(negedge clk);
            check("pre-cancel done", 64'(done_o), 64'd0);
        end
        cancel_i = 1'b1;
        start_i  = 1'b0;
        @(negedge clk);
        cancel_i = 1'b0;
        check("cancel idle", {62'd0, done_o, busy_o}, 64'd0);
        check("cancel result", result_o, last_res);
        run_op("after cancel 9/3", 32'd9, 32'd3, 1'b0, 0);

        // Cancel together with start: the request is dropped.
        start_i    = 1'b1;
        cancel_i   = 1'b1;
        dividend_i = 32'd50;
        divisor_i  = 32'd5;
        @(negedge clk);
        start_i  = 1'b0;
        cancel_i = 1'b0;
        check("cancel+start idle", {62'd0, done_o, busy_o}, 64'd0);
        @(negedge clk);
        check("cancel+start stays idle", {62'd0, done_o, busy_o}, 64'd0);

        // Cancel while holding a result: done drops, result is kept.
        start_i    = 1'b1;
        signed_i   = 1'b0;
        dividend_i = 32'd6;
        divisor_i  = 32'd0;
        repeat (2) @(negedge clk);
        check("zero path done", 64'(done_o), 64'd1);
        check("zero path result", result_o, {32'd6, 32'hFFFF_FFFF});
        start_i  = 1'b0;
        cancel_i = 1'b1;
        @(negedge clk);
        cancel_i = 1'b0;
        check("cancel done idle", {62'd0, done_o, busy_o}, 64'd0);
        check("cancel done result", result_o, {32'd6, 32'hFFFF_FFFF});

        // Reset in the middle of an operation.
        start_i    = 1'b1;
        dividend_i = 32'd12345;
        divisor_i  = 32'd11;
        repeat (5) @(negedge clk);
        rst     = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("mid-busy reset flags", {62'd0, done_o, busy_o}, 64'd0);
        check("mid-busy reset result", result_o, 64'd0);
        @(negedge clk);

        // Randomized back-to-back operations.
        for (int k = 0; k < 40; k++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic        s;
            a = pick_operand(1'b1);
            b = ($urandom_range(0, 9) == 0) ? 32'd0 : pick_operand(1'b0);
            s = 1'($urandom_range(0, 1));
            run_op($sformatf("rand%0d %h/%h s%0d", k, a, b, s), a, b, s, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
